mem_board: RTL and testbench

Board and player controller for the memory card game. It sits directly downstream of the turn-evaluation stage: it consumes that stage's turn result, pair flag and picked card indices, and maintains the 16-card revealed/matched board, the active player, per-player scores and the mismatch display hold. It also feeds the turn stage the `empty` qualifier for the card under the cursor, and drives the display and the end-of-game indication.

---
 rtl/mem_board.sv | 174 +++++++++++++++++
 tb/tb_mem_board.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_board.sv
// Board and player controller for the memory card game.
// Tracks face-up and removed cards, the active player, both scores and the
// mismatch display hold, and reports game end with the latched winner.
//
// Handshake: a pick is accepted only in a cycle where sel_valid=1 and empty=1.
// There is no back-pressure. empty is the ready qualifier for the cursor card,
// and busy=1 means every sel_valid is dropped.
//
// state_dbg encoding: 0=PICK1, 1=PICK2, 2=EVAL, 3=SHOW, 4=DONE.
module mem_board #(
  parameter int CARDS       = 16,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel_valid,
  input  logic [3:0]       sel_index,
  input  logic [1:0]       result,
  input  logic             par,
  input  logic [7:0]       selected1,
  input  logic [7:0]       selected2,
  output logic             empty,
  output logic             player,
  output logic [CARDS-1:0] revealed,
  output logic [CARDS-1:0] matched,
  output logic [3:0]       score1,
  output logic [3:0]       score2,
  output logic             busy,
  output logic             game_over,
  output logic [1:0]       winner,
  output logic [2:0]       state_dbg
);

  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [3:0] SCORE_MAX = 4'd8;

  typedef enum logic [2:0] {
    PICK1 = 3'd0,
    PICK2 = 3'd1,
    EVAL  = 3'd2,
    SHOW  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             player_q, player_d;
  logic [CARDS-1:0] revealed_q, revealed_d;
  logic [CARDS-1:0] matched_q, matched_d;
  logic [3:0]       score1_q, score1_d;
  logic [3:0]       score2_q, score2_d;
  logic             game_over_q, game_over_d;
  logic [1:0]       winner_q, winner_d;
  logic [CW-1:0]    hold_q, hold_d;

  logic [CARDS-1:0] sel_bit;
  logic [CARDS-1:0] pair_bits;
  logic             pick_ok;
  logic             end_game;

  // Only the low nibble of the picked-card indices addresses the board.
  logic unused_sel_hi;
  assign unused_sel_hi = ^{selected1[7:4], selected2[7:4]};

  // Cursor card is selectable only while waiting for a pick and still face-down.
  assign empty = ((state_q == PICK1) || (state_q == PICK2)) &&
                 !revealed_q[sel_index] && !matched_q[sel_index];

  assign busy      = (state_q == EVAL) || (state_q == SHOW) || (state_q == DONE);
  assign player    = player_q;
  assign revealed  = revealed_q;
  assign matched   = matched_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state_dbg = state_q;

  // Next-state and board update; game end overrides picks and evaluation.
  always_comb begin
    state_d     = state_q;
    player_d    = player_q;
    revealed_d  = revealed_q;
    matched_d   = matched_q;
    score1_d    = score1_q;
    score2_d    = score2_q;
    game_over_d = game_over_q;
    winner_d    = winner_q;
    hold_d      = hold_q;

    sel_bit   = CARDS'(1) << sel_index;
    pair_bits = (CARDS'(1) << selected1[3:0]) | (CARDS'(1) << selected2[3:0]);
    pick_ok   = sel_valid && empty;
    end_game  = (result == 2'b10) || (result == 2'b11) || (matched_q == '1);

    if ((state_q != DONE) && end_game) begin
      state_d     = DONE;
      game_over_d = 1'b1;
      if (score1_q > score2_q)      winner_d = 2'b01;
      else if (score1_q < score2_q) winner_d = 2'b10;
      else                          winner_d = 2'b11;
    end else begin
      case (state_q)
        PICK1: begin
          if (pick_ok) begin
            revealed_d = revealed_q | sel_bit;
            state_d    = PICK2;
          end
        end
        PICK2: begin
          if (pick_ok) begin
            revealed_d = revealed_q | sel_bit;
            state_d    = EVAL;
          end
        end
        EVAL: begin
          if (result == 2'b01) begin
            if (par) begin
              matched_d  = matched_q | pair_bits;
              revealed_d = revealed_q & ~pair_bits;
              if (!player_q) begin
                if (score1_q < SCORE_MAX) score1_d = score1_q + 4'd1;
              end else begin
                if (score2_q < SCORE_MAX) score2_d = score2_q + 4'd1;
              end
              state_d = PICK1;
            end else begin
              hold_d  = HOLD_LOAD;
              state_d = SHOW;
            end
          end
        end
        SHOW: begin
          if (hold_q == '0) begin
            revealed_d = '0;
            player_d   = !player_q;
            state_d    = PICK1;
          end else begin
            hold_d = hold_q - CW'(1);
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PICK1;
      player_q    <= 1'b0;
      revealed_q  <= '0;
      matched_q   <= '0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      game_over_q <= 1'b0;
      winner_q    <= 2'b00;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      player_q    <= player_d;
      revealed_q  <= revealed_d;
      matched_q   <= matched_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      game_over_q <= game_over_d;
      winner_q    <= winner_d;
      hold_q      <= hold_d;
    end
  end

endmodule

// File: tb/tb_mem_board.sv
// Bench for mem_board: directed game scenarios followed by random play,
// every cycle checked against a card/turn level model of the game rules.
module tb_mem_board;

  localparam int HOLD = 4;

  // Clock and DUT signals
  logic        clk = 1'b0;
  logic        rst;
  logic        sel_valid;
  logic [3:0]  sel_index;
  logic [1:0]  result;
  logic        par;
  logic [7:0]  selected1;
  logic [7:0]  selected2;
  logic        empty;
  logic        player;
  logic [15:0] revealed;
  logic [15:0] matched;
  logic [3:0]  score1;
  logic [3:0]  score2;
  logic        busy;
  logic        game_over;
  logic [1:0]  winner;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_board #(.CARDS(16), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_index(sel_index),
    .result(result), .par(par), .selected1(selected1), .selected2(selected2),
    .empty(empty), .player(player), .revealed(revealed), .matched(matched),
    .score1(score1), .score2(score2), .busy(busy), .game_over(game_over),
    .winner(winner), .state_dbg(state_dbg)
  );

  // Reference model: board as card sets, turn progress as a pick count,
  // mismatch display as remaining cycles.
  logic [15:0] m_rev, m_mat;
  logic        m_player;
  int          m_s1, m_s2;
  bit          m_over;
  logic [1:0]  m_win;
  int          m_picks;
  int          m_hold;
  logic [3:0]  m_pa, m_pb;

  function automatic bit m_empty(input logic [3:0] i);
    return !m_over && (m_hold == 0) && (m_picks < 2) && !m_rev[i] && !m_mat[i];
  endfunction

  function automatic logic [2:0] m_phase();
    if (m_over)        return 3'd4;
    if (m_hold > 0)    return 3'd3;
    if (m_picks == 2)  return 3'd2;
    if (m_picks == 1)  return 3'd1;
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_rev = '0; m_mat = '0; m_player = 1'b0; m_s1 = 0; m_s2 = 0;
    m_over = 1'b0; m_win = 2'b00; m_picks = 0; m_hold = 0; m_pa = '0; m_pb = '0;
  endtask

  task automatic model_step();
    bit pick;
    logic [15:0] pb;
    pick = sel_valid && m_empty(sel_index);
    pb = (16'd1 << selected1[3:0]) | (16'd1 << selected2[3:0]);
    if (rst) begin
      model_reset();
    end else if (m_over) begin
      // frozen
    end else if (result[1] || (m_mat == 16'hFFFF)) begin
      m_over = 1'b1;
      m_win = (m_s1 > m_s2) ? 2'b01 : (m_s1 < m_s2) ? 2'b10 : 2'b11;
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0) begin
        m_rev = '0; m_player = !m_player; m_picks = 0;
      end
    end else if (m_picks == 2) begin
      if (result == 2'b01) begin
        if (par) begin
          m_mat |= pb;
          m_rev &= ~pb;
          if (!m_player) begin if (m_s1 < 8) m_s1++; end
          else begin if (m_s2 < 8) m_s2++; end
          m_picks = 0;
        end else begin
          m_hold = HOLD;
        end
      end
    end else if (pick) begin
      m_rev[sel_index] = 1'b1;
      if (m_picks == 0) m_pa = sel_index; else m_pb = sel_index;
      m_picks++;
    end
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("player", player, m_player);
    chk("revealed", revealed, m_rev);
    chk("matched", matched, m_mat);
    chk("score1", score1, m_s1[3:0]);
    chk("score2", score2, m_s2[3:0]);
    chk("busy", busy, m_over || (m_hold > 0) || (m_picks == 2));
    chk("game_over", game_over, m_over);
    chk("winner", winner, m_win);
    chk("state", state_dbg, m_phase());
  endtask

  // One clock: check empty before the edge, advance model, check after the edge.
  task automatic cycle();
    @(negedge clk);
    chk("empty", empty, m_empty(sel_index));
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  // Driver tasks
  task automatic idle();
    rst = 1'b0; sel_valid = 1'b0; sel_index = 4'd0; result = 2'b00;
    par = 1'b0; selected1 = 8'd0; selected2 = 8'd0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; cycle(); idle();
  endtask

  task automatic pick(input logic [3:0] i);
    sel_valid = 1'b1; sel_index = i; cycle(); idle();
  endtask

  task automatic turn(input logic [1:0] r, input logic p, input logic [3:0] a, input logic [3:0] b);
    result = r; par = p; selected1 = {4'd0, a}; selected2 = {4'd0, b}; cycle(); idle();
  endtask

  task automatic play(input logic [3:0] a, input logic [3:0] b, input logic p);
    pick(a); pick(b); turn(2'b01, p, a, b);
    if (!p) repeat (HOLD) cycle();
  endtask

  initial begin
    idle();
    model_reset();
    rst = 1'b1;
    cycle();
    idle();
    chk("rst_revealed", revealed, 16'h0000);
    chk("rst_state", state_dbg, 3'd0);
    chk("rst_winner", winner, 2'b00);

    // Two picks reach EVAL; further picks are dropped
    pick(4'd3); pick(4'd7);
    chk("t1_revealed", revealed, 16'h0088);
    chk("t1_state", state_dbg, 3'd2);
    chk("t1_busy", busy, 1'b1);
    pick(4'd5);
    chk("t1_ignored", revealed, 16'h0088);

    // Pair found
    turn(2'b01, 1'b1, 4'd3, 4'd7);
    chk("t2_matched", matched, 16'h0088);
    chk("t2_revealed", revealed, 16'h0000);
    chk("t2_score1", score1, 4'd1);
    chk("t2_player", player, 1'b0);
    sel_index = 4'd3; #1;
    chk("t2_empty3", empty, 1'b0);
    idle();

    // Mismatch held for exactly HOLD cycles
    pick(4'd1); pick(4'd2);
    turn(2'b01, 1'b0, 4'd1, 4'd2);
    for (int k = 0; k < HOLD; k++) begin
      chk("t3_hold", revealed, 16'h0006);
      cycle();
    end
    chk("t3_cleared", revealed, 16'h0000);
    chk("t3_player", player, 1'b1);

    // Same card twice
    pick(4'd4); pick(4'd4);
    chk("t4_state", state_dbg, 3'd1);
    sel_index = 4'd4; #1;
    chk("t4_empty4", empty, 1'b0);
    idle();
    pick(4'd5);
    turn(2'b01, 1'b1, 4'd4, 4'd5);
    chk("t4_score2", score2, 4'd1);

    // Tie result beats a simultaneous pick, then everything freezes
    result = 2'b11; sel_valid = 1'b1; sel_index = 4'd0;
    cycle(); idle();
    chk("t5_over", game_over, 1'b1);
    chk("t5_winner", winner, 2'b11);
    chk("t5_nopick", revealed, 16'h0000);
    for (int k = 0; k < 10; k++) begin
      sel_valid = 1'($urandom); sel_index = 4'($urandom); result = 2'($urandom);
      par = 1'($urandom); selected1 = 8'($urandom); selected2 = 8'($urandom);
      cycle();
      chk("t5_frozen", matched, 16'h00B8);
    end

    // Reset during the second SHOW cycle
    do_reset();
    pick(4'd1); pick(4'd2);
    turn(2'b01, 1'b0, 4'd1, 4'd2);
    cycle();
    rst = 1'b1; cycle(); idle();
    chk("t6_revealed", revealed, 16'h0000);
    chk("t6_state", state_dbg, 3'd0);
    chk("t6_busy", busy, 1'b0);

    // Full board 4:4 ends the game by itself
    do_reset();
    play(4'd0, 4'd1, 1'b1); play(4'd2, 4'd3, 1'b1);
    play(4'd4, 4'd5, 1'b1); play(4'd6, 4'd7, 1'b1);
    play(4'd8, 4'd9, 1'b0);
    play(4'd8, 4'd9, 1'b1); play(4'd10, 4'd11, 1'b1);
    play(4'd12, 4'd13, 1'b1); play(4'd14, 4'd15, 1'b1);
    chk("t7_matched", matched, 16'hFFFF);
    cycle();
    chk("t7_over", game_over, 1'b1);
    chk("t7_winner", winner, 2'b11);

    // J1 ahead, then J2 ahead
    do_reset();
    play(4'd0, 4'd1, 1'b1);
    turn(2'b10, 1'b0, 4'd0, 4'd0);
    chk("t8_j1", winner, 2'b01);
    do_reset();
    play(4'd0, 4'd1, 1'b0);
    play(4'd2, 4'd3, 1'b1);
    turn(2'b10, 1'b0, 4'd0, 4'd0);
    chk("t8_j2", winner, 2'b10);

    // Random play
    for (int g = 0; g < 6; g++) begin
      do_reset();
      for (int n = 0; n < 300; n++) begin
        int r;
        rst = ($urandom_range(0, 399) == 0);
        sel_valid = 1'($urandom_range(0, 1));
        sel_index = 4'($urandom);
        par = 1'($urandom);
        selected1 = 8'($urandom);
        selected2 = 8'($urandom);
        r = $urandom_range(0, 199);
        if ((m_picks == 2) && (m_hold == 0) && !m_over && (r < 80)) begin
          result = 2'b01;
          par = ($urandom_range(0, 2) != 0);
          selected1 = {4'($urandom), m_pa};
          selected2 = {4'($urandom), m_pb};
        end else if (r < 81) begin
          result = 2'($urandom_range(2, 3));
        end else if (r < 95) begin
          result = 2'b01;
        end else begin
          result = 2'b00;
        end
        cycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
